fust_table: RTL

Parametrised functional-unit status table for the tensor-core dispatch stage; successor to the single-snapshot scalar FU status register. It holds one entry per functional unit (op row, two source tags, per-operand ready bits and a lifecycle state). Entries wake up on writeback tag broadcasts, and a round-robin arbiter picks one ready entry per cycle for issue. It sits between decode/dispatch and the functional units and frees each entry on that unit's completion.

---
 rtl/fust_table.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/fust_table.sv
// fust_table: functional-unit status table for the tensor-core dispatch stage.
// One entry per functional unit holds an opaque op row, two source producer
// tags, per-operand ready bits and a lifecycle state (FREE/WAIT/READY/ISSUED).
// Entries wake up on writeback tag broadcasts, and a round-robin selector
// offers one READY entry per cycle for issue.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   flush                synchronous clear of every entry and the RR pointer
//   disp_*               dispatch request (target entry, row, tags, ready bits)
//   disp_ready           target entry disp_fu is FREE
//   wb_valid, wb_tag     writeback tag broadcast
//   issue_valid/fu/row   currently selected READY entry (row 0 when none)
//   issue_ack            functional unit accepts the offered op
//   done_valid, done_fu  completion of an ISSUED entry
//   busy                 per-entry state != FREE
module fust_table #(
    parameter int NUM_FU = 4,
    parameter int OP_W   = 32,
    parameter int TAG_W  = 5,
    parameter int FU_W   = $clog2(NUM_FU)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              disp_valid,
    input  logic [FU_W-1:0]   disp_fu,
    input  logic [OP_W-1:0]   disp_row,
    input  logic [TAG_W-1:0]  disp_t1,
    input  logic [TAG_W-1:0]  disp_t2,
    input  logic              disp_r1,
    input  logic              disp_r2,
    output logic              disp_ready,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    output logic              issue_valid,
    output logic [FU_W-1:0]   issue_fu,
    output logic [OP_W-1:0]   issue_row,
    input  logic              issue_ack,
    input  logic              done_valid,
    input  logic [FU_W-1:0]   done_fu,
    output logic [NUM_FU-1:0] busy
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_READY  = 2'd2,
        ST_ISSUED = 2'd3
    } ent_state_e;

    ent_state_e        state_r [NUM_FU];
    logic [OP_W-1:0]   row_r   [NUM_FU];
    logic [TAG_W-1:0]  t1_r    [NUM_FU];
    logic [TAG_W-1:0]  t2_r    [NUM_FU];
    logic              r1_r    [NUM_FU];
    logic              r2_r    [NUM_FU];
    logic [FU_W-1:0]   rr_r;

    logic              sel_found_s;
    logic [FU_W-1:0]   sel_idx_s;
    logic [FU_W-1:0]   cand_s;
    logic              disp_acc_s;
    logic              issue_fire_s;
    logic              disp_h1_s;
    logic              disp_h2_s;
    logic [NUM_FU-1:0] wake1_s;
    logic [NUM_FU-1:0] wake2_s;

    // (base + off) mod NUM_FU; NUM_FU need not be a power of two.
    function automatic logic [FU_W-1:0] wrap_idx(input logic [FU_W-1:0] base, input int off);
        return FU_W'((int'(base) + off) % NUM_FU);
    endfunction

    // Round-robin select: first READY entry at or after rr, wrapping.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        cand_s      = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            cand_s = wrap_idx(rr_r, i);
            if (!sel_found_s && (state_r[cand_s] == ST_READY)) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Output decode; explicit index compare keeps out-of-range FU indices harmless.
    always_comb begin
        disp_ready  = 1'b0;
        issue_row   = '0;
        busy        = '0;
        issue_valid = sel_found_s;
        issue_fu    = sel_idx_s;
        for (int i = 0; i < NUM_FU; i++) begin
            busy[i] = (state_r[i] != ST_FREE);
            if (disp_fu == FU_W'(i)) begin
                disp_ready = (state_r[i] == ST_FREE);
            end else begin
                disp_ready = disp_ready;
            end
            if (sel_found_s && (sel_idx_s == FU_W'(i))) begin
                issue_row = row_r[i];
            end else begin
                issue_row = issue_row;
            end
        end
    end

    // Handshake qualifiers and tag matches, including same-cycle capture at dispatch.
    always_comb begin
        disp_acc_s   = disp_valid & disp_ready & ~flush;
        issue_fire_s = sel_found_s & issue_ack;
        disp_h1_s    = disp_r1 | (wb_valid & (wb_tag == disp_t1));
        disp_h2_s    = disp_r2 | (wb_valid & (wb_tag == disp_t2));
        wake1_s      = '0;
        wake2_s      = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            wake1_s[i] = wb_valid & (wb_tag == t1_r[i]);
            wake2_s[i] = wb_valid & (wb_tag == t2_r[i]);
        end
    end

    // Entry lifecycle and RR pointer; each state only reacts to its own event,
    // so done vs dispatch on one entry resolves from the pre-edge state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_FU; i++) begin
                state_r[i] <= ST_FREE;
                row_r[i]   <= '0;
                t1_r[i]    <= '0;
                t2_r[i]    <= '0;
                r1_r[i]    <= 1'b0;
                r2_r[i]    <= 1'b0;
            end
            rr_r <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                state_r[i] <= ST_FREE;
                r1_r[i]    <= 1'b0;
                r2_r[i]    <= 1'b0;
            end
            rr_r <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                case (state_r[i])
                    ST_FREE: begin
                        if (disp_acc_s && (disp_fu == FU_W'(i))) begin
                            row_r[i]   <= disp_row;
                            t1_r[i]    <= disp_t1;
                            t2_r[i]    <= disp_t2;
                            r1_r[i]    <= disp_h1_s;
                            r2_r[i]    <= disp_h2_s;
                            state_r[i] <= (disp_h1_s && disp_h2_s) ? ST_READY : ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        r1_r[i]    <= r1_r[i] | wake1_s[i];
                        r2_r[i]    <= r2_r[i] | wake2_s[i];
                        state_r[i] <= ((r1_r[i] | wake1_s[i]) && (r2_r[i] | wake2_s[i]))
                                      ? ST_READY : ST_WAIT;
                    end
                    ST_READY: begin
                        if (issue_fire_s && (sel_idx_s == FU_W'(i))) begin
                            state_r[i] <= ST_ISSUED;
                        end
                    end
                    ST_ISSUED: begin
                        if (done_valid && (done_fu == FU_W'(i))) begin
                            state_r[i] <= ST_FREE;
                            r1_r[i]    <= 1'b0;
                            r2_r[i]    <= 1'b0;
                        end
                    end
                    default: begin
                        state_r[i] <= ST_FREE;
                    end
                endcase
            end
            if (issue_fire_s) begin
                rr_r <= wrap_idx(sel_idx_s, 1);
            end
        end
    end

endmodule
